// File: rtl/hack_alu_pipe.sv
// rtl/hack_alu_pipe.sv - two-stage Hack ALU with valid/ready handshakes and op counter; ALU_OVF_EN adds overflow flags
module hack_alu_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       zxnx,
  input  logic [1:0]       zyny,
  input  logic [1:0]       fno,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
`ifdef ALU_OVF_EN
  output logic             ovf,
  output logic             ovf_sticky,
  input  logic             ovf_clr,
`endif
  output logic [CNT_W-1:0] op_cnt
);

  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] s1_xb_q, s1_xb_d, s1_yb_q, s1_yb_d;
  logic             s1_f_q, s1_f_d, s1_no_q, s1_no_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d, ng_q, ng_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

  logic             s2_adv, s1_adv, out_hs;
  logic [WIDTH-1:0] xa, xb, ya, yb, sum, res_r, res;

  // Handshake control: a stage advances when empty or when the stage after it drains
  always_comb begin
    s2_adv   = !s2_v_q || out_ready;
    s1_adv   = !s1_v_q || s2_adv;
    out_hs   = s2_v_q && out_ready;
    in_ready = s1_adv;
  end

  // Stage 1 next state: zero/negate operand conditioning on accept
  always_comb begin
    xa      = zxnx[1] ? '0 : x;
    xb      = zxnx[0] ? ~xa : xa;
    ya      = zyny[1] ? '0 : y;
    yb      = zyny[0] ? ~ya : ya;
    s1_v_d  = s1_v_q;
    s1_xb_d = s1_xb_q;
    s1_yb_d = s1_yb_q;
    s1_f_d  = s1_f_q;
    s1_no_d = s1_no_q;
    if (s1_adv) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_xb_d = xb;
        s1_yb_d = yb;
        s1_f_d  = fno[1];
        s1_no_d = fno[0];
      end
    end
  end

  // Stage 2 next state: add/and, optional output negate, flags; holds while stalled
  always_comb begin
    sum      = s1_xb_q + s1_yb_q;
    res_r    = s1_f_q ? sum : (s1_xb_q & s1_yb_q);
    res      = s1_no_q ? ~res_r : res_r;
    s2_v_d   = s2_v_q;
    out_d    = out_q;
    zr_d     = zr_q;
    ng_d     = ng_q;
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        out_d = res;
        zr_d  = (res == '0);
        ng_d  = res[WIDTH-1];
      end
    end
    op_cnt_d = op_cnt_q + {{(CNT_W-1){1'b0}}, out_hs};
  end

  // Pipeline and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q   <= 1'b0;
      s1_xb_q  <= '0;
      s1_yb_q  <= '0;
      s1_f_q   <= 1'b0;
      s1_no_q  <= 1'b0;
      s2_v_q   <= 1'b0;
      out_q    <= '0;
      zr_q     <= 1'b0;
      ng_q     <= 1'b0;
      op_cnt_q <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_xb_q  <= s1_xb_d;
      s1_yb_q  <= s1_yb_d;
      s1_f_q   <= s1_f_d;
      s1_no_q  <= s1_no_d;
      s2_v_q   <= s2_v_d;
      out_q    <= out_d;
      zr_q     <= zr_d;
      ng_q     <= ng_d;
      op_cnt_q <= op_cnt_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign op_cnt    = op_cnt_q;

`ifdef ALU_OVF_EN
  logic ovf_q, ovf_d, ovf_sticky_q, ovf_sticky_d;

  // Signed add overflow travels with the result; sticky set beats clear
  always_comb begin
    ovf_d = ovf_q;
    if (s2_adv && s1_v_q)
      ovf_d = s1_f_q && (s1_xb_q[WIDTH-1] == s1_yb_q[WIDTH-1]) &&
              (sum[WIDTH-1] != s1_xb_q[WIDTH-1]);
    ovf_sticky_d = ovf_sticky_q;
    if (out_hs && ovf_q)
      ovf_sticky_d = 1'b1;
    else if (ovf_clr)
      ovf_sticky_d = 1'b0;
  end

  // Overflow flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      ovf_q        <= ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf        = ovf_q;
  assign ovf_sticky = ovf_sticky_q;
`endif

endmodule

// File: tb/tb_hack_alu_pipe.sv
// tb/tb_hack_alu_pipe.sv - randomized and directed self-checking bench for hack_alu_pipe against an occupancy/queue model
module tb_hack_alu_pipe;
  localparam int W  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  x = '0, y = '0;
  logic [1:0]    zxnx = '0, zyny = '0, fno = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out;
  logic          zr, ng;
  logic [CW-1:0] op_cnt;
`ifdef ALU_OVF_EN
  logic          ovf, ovf_sticky;
  logic          ovf_clr = 1'b0;
  logic          sticky_m = 1'b0;
`endif

  hack_alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .zxnx(zxnx), .zyny(zyny), .fno(fno),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .zr(zr), .ng(ng),
`ifdef ALU_OVF_EN
    .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr),
`endif
    .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] o;
    logic         zr;
    logic         ng;
    logic         ovf;
    int           age;
  } ent_t;

  ent_t        q[$];
  logic [17:0] got_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          ops_done = 0;
  bit          stall_prev = 0;
  logic [17:0] held = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t ref_op(input logic [W-1:0] xi, input logic [W-1:0] yi,
                                  input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    logic [W-1:0] xv, yv, r;
    int s;
    ent_t e;
    xv = a[1] ? '0 : xi;
    if (a[0]) xv = ~xv;
    yv = b[1] ? '0 : yi;
    if (b[0]) yv = ~yv;
    s = int'($signed(xv)) + int'($signed(yv));
    r = c[1] ? W'(s) : (xv & yv);
    if (c[0]) r = ~r;
    e.o   = r;
    e.zr  = (r == '0);
    e.ng  = r[W-1];
    e.ovf = c[1] && (s > 32767 || s < -32768);
    e.age = 0;
    return e;
  endfunction

  // One clock cycle: called at posedge+1, samples at negedge, returns at next posedge+1
  task automatic step(input bit iv, input bit ordy, input bit clr, output bit acc);
    int   n;
    bit   ov_m, hs;
    ent_t e;
    in_valid  = iv;
    out_ready = ordy;
`ifdef ALU_OVF_EN
    ovf_clr = clr;
`endif
    @(negedge clk);
    n = q.size();
    ov_m = 1'b0;
    if (n > 0) ov_m = (q[0].age >= 2);
    check("in_ready", {31'd0, in_ready}, {31'd0, (n < 2) || ordy});
    check("out_valid", {31'd0, out_valid}, {31'd0, ov_m});
    check("op_cnt", {27'd0, op_cnt}, ops_done % 32);
    if (stall_prev) check("stall_hold", {14'd0, out, zr, ng}, {14'd0, held});
`ifdef ALU_OVF_EN
    check("ovf_sticky", {31'd0, ovf_sticky}, {31'd0, sticky_m});
`endif
    acc = iv && ((n < 2) || ordy);
    hs  = ov_m && ordy;
    if (hs) begin
      e = q.pop_front();
      check("out", {16'd0, out}, {16'd0, e.o});
      check("zr", {31'd0, zr}, {31'd0, e.zr});
      check("ng", {31'd0, ng}, {31'd0, e.ng});
`ifdef ALU_OVF_EN
      check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
      if (e.ovf) sticky_m = 1'b1;
      else if (clr) sticky_m = 1'b0;
`endif
      got_q.push_back({zr, ng, out});
      ops_done++;
    end
`ifdef ALU_OVF_EN
    else if (clr) sticky_m = 1'b0;
`endif
    if (acc) q.push_back(ref_op(x, y, zxnx, zyny, fno));
    stall_prev = ov_m && !ordy;
    held = {out, zr, ng};
    @(posedge clk);
    #1;
    foreach (q[i]) q[i].age++;
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 20 && q.size() > 0; i++) step(0, 1, 0, a);
    check("drain_timeout", q.size(), 0);
  endtask

  task automatic issue(input logic [W-1:0] xi, input logic [W-1:0] yi,
                       input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    bit acc;
    x = xi; y = yi; zxnx = a; zyny = b; fno = c;
    step(1, 1, 0, acc);
    check("issue_accept", {31'd0, acc}, 1);
  endtask

  initial begin
    bit   acc;
    int   cnt0, accepts, issued;
    rst_n = 1'b0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out", {16'd0, out}, 0);
    check("rst_zr_ng", {30'd0, zr, ng}, 0);
    check("rst_op_cnt", {27'd0, op_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed values with x=100, y=-200
    got_q.delete();
    issue(16'd100, 16'hFF38, 2'b10, 2'b10, 2'b10);
    issue(16'd100, 16'hFF38, 2'b11, 2'b11, 2'b11);
    issue(16'd100, 16'hFF38, 2'b00, 2'b00, 2'b10);
    issue(16'd100, 16'hFF38, 2'b01, 2'b00, 2'b11);
    issue(16'd100, 16'hFF38, 2'b00, 2'b00, 2'b00);
    drain();
    check("dir_count", got_q.size(), 5);
    if (got_q.size() == 5) begin
      check("t1_zero", {14'd0, got_q[0]}, {14'd0, 2'b10, 16'h0000});
      check("t1_one", {14'd0, got_q[1]}, {14'd0, 2'b00, 16'h0001});
      check("t2_sum", {14'd0, got_q[2]}, {14'd0, 2'b01, 16'hFF9C});
      check("t2_xmy", {14'd0, got_q[3]}, {14'd0, 2'b00, 16'h012C});
      check("t2_and", {14'd0, got_q[4]}, {14'd0, 2'b00, 16'h0020});
    end

    // Backpressure: five stalled cycles accept only two ops, then drain in order
    accepts = 0;
    for (int i = 0; i < 5; i++) begin
      x = 16'($urandom); y = 16'($urandom);
      zxnx = 2'($urandom); zyny = 2'($urandom); fno = 2'($urandom);
      step(1, 0, 0, acc);
      if (acc) accepts++;
    end
    check("t4_accepts", accepts, 2);
    check("t4_in_ready", {31'd0, in_ready}, 0);
    drain();

    // Async reset with two ops in flight
    issue(16'd1, 16'd2, 2'b00, 2'b00, 2'b10);
    issue(16'd3, 16'd4, 2'b00, 2'b00, 2'b10);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", {31'd0, out_valid}, 0);
    check("t5_op_cnt", {27'd0, op_cnt}, 0);
    q.delete();
    ops_done = 0;
    stall_prev = 0;
`ifdef ALU_OVF_EN
    sticky_m = 1'b0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t5_in_ready", {31'd0, in_ready}, 1);
    got_q.delete();
    issue(16'd5, 16'd6, 2'b00, 2'b00, 2'b10);
    drain();
    check("t5_next_op", got_q.size(), 1);
    if (got_q.size() == 1) check("t5_next_val", {14'd0, got_q[0]}, {14'd0, 2'b00, 16'd11});

    // 18 back-to-back ops with out_ready toggling
    cnt0 = ops_done;
    issued = 0;
    x = 16'($urandom); y = 16'($urandom);
    zxnx = 2'($urandom); zyny = 2'($urandom); fno = 2'($urandom);
    for (int k = 0; k < 80 && issued < 18; k++) begin
      step(1, (k % 2) == 0, 0, acc);
      if (acc) begin
        issued++;
        x = 16'($urandom); y = 16'($urandom);
        zxnx = 2'($urandom); zyny = 2'($urandom); fno = 2'($urandom);
      end
    end
    check("t3_issued", issued, 18);
    drain();
    check("t3_op_cnt", {27'd0, op_cnt}, (cnt0 + 18) % 32);

`ifdef ALU_OVF_EN
    // Overflow flag and sticky behaviour
    got_q.delete();
    step(0, 1, 1, acc);
    issue(16'h7FFF, 16'h0001, 2'b00, 2'b00, 2'b10);
    in_valid = 1'b0;
    step(0, 1, 0, acc);
    @(negedge clk);
    check("t6_out", {16'd0, out}, 16'h8000);
    check("t6_ovf", {31'd0, ovf}, 1);
    @(posedge clk);
    #1;
    foreach (q[i]) q[i].age++;
    drain();
    for (int i = 0; i < 3; i++) step(0, 1, 0, acc);
    check("t6_sticky_hold", {31'd0, ovf_sticky}, 1);
    step(0, 1, 1, acc);
    check("t6_sticky_clr", {31'd0, ovf_sticky}, 0);
    issue(16'h7FFF, 16'h0001, 2'b00, 2'b00, 2'b10);
    step(0, 1, 0, acc);
    step(0, 1, 1, acc);
    check("t6_set_wins", {31'd0, ovf_sticky}, 1);
    drain();
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      x = ($urandom % 8 == 0) ? 16'h7FFF : 16'($urandom);
      y = ($urandom % 8 == 0) ? 16'h8000 : 16'($urandom);
      zxnx = 2'($urandom); zyny = 2'($urandom); fno = 2'($urandom);
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 8) == 0, acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
